xor_arbiter: RTL and testbench

XOR_ARBITER -- requirements
Module: xor_arbiter

---
 rtl/xor_arbiter.sv | 96 +++++++++
 tb/tb_xor_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_arbiter.sv
// xor_arbiter: round-robin arbiter sharing one external bitwise-XOR datapath
// between two requesters. Accepted operands are registered onto xo_a/xo_b.
// The combinational result on xo_out is captured one cycle later and held
// until the consumer takes it.
module xor_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] xo_a,
    output logic [WIDTH-1:0] xo_b,
    input  logic [WIDTH-1:0] xo_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;

    // Holds the most recently granted requester; reset value 1 gives requester 0 first priority.
    logic rr_ptr;
    logic gnt0;
    logic gnt1;

    // Round-robin grant: a lone requester always wins; on contention the one not granted last wins.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || rr_ptr);
        gnt1 = req1_valid && (!req0_valid || !rr_ptr);
    end

    // Ready is only offered in IDLE, and is suppressed while reset is held.
    assign req0_ready = rst_n && (state == IDLE) && gnt0;
    assign req1_ready = rst_n && (state == IDLE) && gnt1;

    // Control FSM: accept operands in IDLE, capture the XOR result in EXEC, hold it in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b1;
            xo_a      <= '0;
            xo_b      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        xo_a   <= gnt1 ? req1_a : req0_a;
                        xo_b   <= gnt1 ? req1_b : req0_b;
                        res_id <= gnt1;
                        rr_ptr <= gnt1;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // The datapath has had a full cycle to settle on the registered operands.
                    res_data  <= xo_out;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_arbiter.sv
// Self-checking bench for xor_arbiter: table-driven single transactions plus
// hand-written sequences for contention, backpressure, late requests, reset
// in HOLD and a withdrawn request. Expected results go through a scoreboard.
module tb_xor_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] xo_a, xo_b, xo_out;
    logic         res_valid, res_ready;
    logic [W-1:0] res_data;
    logic         res_id;
    logic         busy;

    // External shared datapath: plain bitwise XOR.
    assign xo_out = xo_a ^ xo_b;

    always #5 clk = ~clk;

    xor_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .xo_a(xo_a), .xo_b(xo_b), .xo_out(xo_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    typedef struct {
        logic         v0, v1;
        logic [W-1:0] a0, b0, a1, b1;
        logic         id;
        logic [W-1:0] data;
    } vec_t;

    typedef struct {
        logic         id;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb_empty: got result %h with nothing expected", tag, res_data);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, res_data, e.data);
            chk({tag, "_id"}, W'(res_id), W'(e.id));
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_res_valid"}, W'(res_valid), 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_id"}, W'(res_id), 0);
        chk({tag, "_xo_a"}, xo_a, 0);
        chk({tag, "_xo_b"}, xo_b, 0);
        chk({tag, "_busy"}, W'(busy), 0);
        chk({tag, "_ready0"}, W'(req0_ready), 0);
        chk({tag, "_ready1"}, W'(req1_ready), 0);
    endtask

    // One complete transaction with res_ready held high.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        req0_valid = v.v0; req1_valid = v.v1;
        req0_a = v.a0; req0_b = v.b0; req1_a = v.a1; req1_b = v.b1;
        res_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_ready0", idx), W'(req0_ready), W'(v.id == 1'b0));
        chk($sformatf("v%0d_ready1", idx), W'(req1_ready), W'(v.id == 1'b1));
        chk($sformatf("v%0d_busy_idle", idx), W'(busy), 0);
        sb.push_back('{id: v.id, data: v.data});
        @(posedge clk); #1;
        chk($sformatf("v%0d_busy_exec", idx), W'(busy), 1);
        chk($sformatf("v%0d_xo_a", idx), xo_a, v.id ? v.a1 : v.a0);
        chk($sformatf("v%0d_xo_b", idx), xo_b, v.id ? v.b1 : v.b0);
        chk($sformatf("v%0d_exec_ready", idx), W'({req0_ready, req1_ready}), 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        @(posedge clk); #1;
        while (!res_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("v%0d_latency", idx), W'(n), 0);
        check_result($sformatf("v%0d", idx));
        @(posedge clk); #1;
        chk($sformatf("v%0d_res_valid_clr", idx), W'(res_valid), 0);
        chk($sformatf("v%0d_busy_done", idx), W'(busy), 0);
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants, results, last_cyc, exp_g;
        logic g;

        vecs[0] = '{v0:1, v1:0, a0:32'hFFFF0000, b0:32'h0F0F0F0F, a1:0, b1:0, id:0, data:32'hF0F00F0F};
        vecs[1] = '{v0:0, v1:1, a0:0, b0:0, a1:32'hDEADBEEF, b1:32'hDEADBEEF, id:1, data:32'h00000000};
        vecs[2] = '{v0:1, v1:0, a0:32'hDEADBEEF, b0:32'h0, a1:0, b1:0, id:0, data:32'hDEADBEEF};
        vecs[3] = '{v0:1, v1:1, a0:32'h12345678, b0:32'h0, a1:32'hA5A5A5A5, b1:32'h5A5A5A5A, id:1, data:32'hFFFFFFFF};
        vecs[4] = '{v0:1, v1:1, a0:32'h0F0F0F0F, b0:32'h00FF00FF, a1:32'h11111111, b1:32'h1, id:0, data:32'h0FF00FF0};
        vecs[5] = '{v0:0, v1:1, a0:0, b0:0, a1:32'h80000001, b1:32'h00000001, id:1, data:32'h80000000};

        // Reset state, with both requesters valid.
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '1; req0_b = '1; req1_a = '1; req1_b = '1;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Contention: both valid continuously, grants must alternate 0,1,0,1 three cycles apart.
        @(negedge clk);
        req0_a = 32'h11110000; req0_b = 32'h00001111;
        req1_a = 32'hFF00FF00; req1_b = 32'hF0F0F0F0;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        grants = 0; results = 0; last_cyc = 0; exp_g = 0;
        for (int cyc = 0; cyc < 40 && results < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (grants == 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            if (res_valid) begin
                check_result("rr");
                results++;
            end
            if (req0_ready || req1_ready) begin
                g = req1_ready;
                chk("rr_one_hot", W'(req0_ready & req1_ready), 0);
                chk("rr_order", W'(g), W'(exp_g));
                if (grants > 0) chk("rr_spacing", W'(cyc - last_cyc), 3);
                sb.push_back('{id: exp_g[0], data: exp_g[0] ? 32'h0FF00FF0 : 32'h11111111});
                last_cyc = cyc;
                exp_g = 1 - exp_g;
                grants++;
            end
        end
        chk("rr_grants", W'(grants), 4);
        chk("rr_results", W'(results), 4);
        sb.delete();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;

        // Backpressure with a late req1 arriving while busy with req0.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'hCAFEBABE; req0_b = 32'h0; res_ready = 1'b0;
        #1;
        chk("bp_ready0", W'(req0_ready), 1);
        sb.push_back('{id: 1'b0, data: 32'hCAFEBABE});
        @(posedge clk); #1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h13579BDF; req1_b = 32'h0F0F0F0F;
        #1;
        chk("late_ready1_exec", W'(req1_ready), 0);
        @(posedge clk); #1;
        chk("bp_res_valid", W'(res_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk($sformatf("bp%0d_valid", i), W'(res_valid), 1);
            chk($sformatf("bp%0d_data", i), res_data, 32'hCAFEBABE);
            chk($sformatf("bp%0d_id", i), W'(res_id), 0);
            chk($sformatf("bp%0d_busy", i), W'(busy), 1);
            chk($sformatf("bp%0d_ready", i), W'({req0_ready, req1_ready}), 0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        check_result("bp");
        @(posedge clk); #1;
        chk("bp_busy_idle", W'(busy), 0);
        chk("bp_res_valid_clr", W'(res_valid), 0);
        chk("late_ready1_idle", W'(req1_ready), 1);
        sb.push_back('{id: 1'b1, data: 32'h1C5894D0});
        @(posedge clk); #1;
        chk("late_busy", W'(busy), 1);
        chk("late_xo_a", xo_a, 32'h13579BDF);
        @(negedge clk);
        req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("late_res_valid", W'(res_valid), 1);
        check_result("late");
        @(posedge clk); #1;
        chk("late_busy_done", W'(busy), 0);

        // Asynchronous reset while holding a result.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'h0000FFFF; req0_b = 32'hFFFFFFFF; res_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'hAAAA5555; req1_b = 32'h0;
        @(posedge clk); #1;
        chk("rst_hold_valid", W'(res_valid), 1);
        chk("rst_hold_data", res_data, 32'hFFFF0000);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready1", W'(req1_ready), 1);
        chk("post_rst_ready0", W'(req0_ready), 0);
        sb.push_back('{id: 1'b1, data: 32'hAAAA5555});
        @(posedge clk); #1;
        chk("post_rst_busy", W'(busy), 1);
        chk("post_rst_xo_a", xo_a, 32'hAAAA5555);
        @(negedge clk);
        req1_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_res_valid", W'(res_valid), 1);
        check_result("post_rst");
        @(posedge clk); #1;
        chk("post_rst_busy_done", W'(busy), 0);

        // Request withdrawn before the edge must leave no trace.
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 32'h12345678;
        #1;
        chk("drop_ready_up", W'(req0_ready), 1);
        #2;
        req0_valid = 1'b0;
        #1;
        chk("drop_ready_down", W'(req0_ready), 0);
        @(posedge clk); #1;
        chk("drop_busy", W'(busy), 0);
        chk("drop_xo_a", xo_a, 32'hAAAA5555);
        chk("drop_res_valid", W'(res_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
